// File: rtl/move_sequencer.sv
// move_sequencer: takes one 2048 move through a single shared line-merge unit, spawns a tile, then strobes the boxes.
// Optional build macro FOUR_TILE_EN: a spawned tile is exponent 2 when lfsr[7:4] == 0.
module move_sequencer #(
  parameter logic [15:0] SEED    = 16'hACE1,
  parameter int unsigned WIN_EXP = 11
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [3:0]  direction,
  input  logic [63:0] oldvalues,
  output logic [63:0] newvalues,
  output logic        enable,
  output logic        busy,
  output logic [1:0]  endstatus
);

  localparam logic [3:0] S_INIT1  = 4'd0;
  localparam logic [3:0] S_INIT2  = 4'd1;
  localparam logic [3:0] S_IDLE   = 4'd2;
  localparam logic [3:0] S_LOAD   = 4'd3;
  localparam logic [3:0] S_LINE0  = 4'd4;
  localparam logic [3:0] S_LINE1  = 4'd5;
  localparam logic [3:0] S_LINE2  = 4'd6;
  localparam logic [3:0] S_LINE3  = 4'd7;
  localparam logic [3:0] S_SPAWN  = 4'd8;
  localparam logic [3:0] S_COMMIT = 4'd9;
  localparam logic [3:0] S_CHECK  = 4'd10;
  localparam logic [3:0] S_WAIT   = 4'd11;

  localparam logic [3:0] WIN = 4'(WIN_EXP);

  // Element [~i] holds cell i, so the packed board matches the [63-4i -: 4] layout.
  typedef logic [15:0][3:0] board_t;
  typedef logic [3:0][3:0]  line_t;

  logic [3:0]  state_q, state_d;
  board_t      work_q, work_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [3:0]  dir_q, dir_d;
  logic [3:0]  idx_q, idx_d;
  logic        changed_q, changed_d;
  logic        init_q, init_d;
  logic [1:0]  status_q, status_d;

  logic        press_ok;
  logic [3:0]  tile;
  logic [1:0]  line_k;
  logic [3:0][3:0] line_idx;
  line_t       line_in, line_out;

  // Cell index {row, col} of position p (head first) on line k.
  function automatic logic [3:0] cell_of(input logic [3:0] dir, input logic [1:0] k,
                                         input logic [1:0] p);
    logic [1:0] rp;
    rp = ~p;
    if (dir[3])      cell_of = {p, k};
    else if (dir[2]) cell_of = {rp, k};
    else if (dir[1]) cell_of = {k, p};
    else             cell_of = {k, rp};
  endfunction

  function automatic line_t merge_line(input line_t in);
    line_t           comp, res;
    logic [4:0][3:0] ext;
    logic [1:0]      n, w;
    logic            skip;
    comp = '0;
    n    = '0;
    for (int unsigned p = 0; p < 4; p++) begin
      if (in[2'(p)] != 4'd0) begin
        comp[n] = in[2'(p)];
        n       = n + 2'd1;
      end
    end
    ext  = {4'h0, comp};
    res  = '0;
    w    = '0;
    skip = 1'b0;
    for (int unsigned p = 0; p < 4; p++) begin
      if (skip) begin
        skip = 1'b0;
      end else if (ext[3'(p)] != 4'd0) begin
        if (ext[3'(p)] == ext[3'(p + 1)] && ext[3'(p)] != 4'hF) begin
          res[w] = ext[3'(p)] + 4'd1;
          skip   = 1'b1;
        end else begin
          res[w] = ext[3'(p)];
        end
        w = w + 2'd1;
      end
    end
    return res;
  endfunction

  function automatic logic [1:0] board_status(input board_t b);
    logic won, empty, pair;
    won   = 1'b0;
    empty = 1'b0;
    pair  = 1'b0;
    for (int unsigned c = 0; c < 16; c++) begin
      if (b[4'(c)] >= WIN)  won   = 1'b1;
      if (b[4'(c)] == 4'd0) empty = 1'b1;
    end
    for (int unsigned r = 0; r < 4; r++) begin
      for (int unsigned c = 0; c < 3; c++) begin
        if (b[~{2'(r), 2'(c)}] == b[~{2'(r), 2'(c + 1)}]) pair = 1'b1;
        if (b[~{2'(c), 2'(r)}] == b[~{2'(c + 1), 2'(r)}]) pair = 1'b1;
      end
    end
    if (won)                 board_status = 2'b01;
    else if (!empty && !pair) board_status = 2'b10;
    else                     board_status = 2'b00;
  endfunction

  assign press_ok = (status_q == 2'b00) && (direction != 4'd0) &&
                    ((direction & (direction - 4'd1)) == 4'd0);

`ifdef FOUR_TILE_EN
  assign tile = (lfsr_q[7:4] == 4'd0) ? 4'd2 : 4'd1;
`else
  assign tile = 4'd1;
`endif

  assign lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

  always_comb begin
    case (state_q)
      S_LINE1: line_k = 2'd1;
      S_LINE2: line_k = 2'd2;
      S_LINE3: line_k = 2'd3;
      default: line_k = 2'd0;
    endcase
    line_idx = '0;
    line_in  = '0;
    for (int unsigned p = 0; p < 4; p++) begin
      line_idx[2'(p)] = cell_of(dir_q, line_k, 2'(p));
      line_in[2'(p)]  = work_q[~line_idx[2'(p)]];
    end
    line_out = merge_line(line_in);
  end

  always_comb begin
    state_d   = state_q;
    work_d    = work_q;
    dir_d     = dir_q;
    idx_d     = idx_q;
    changed_d = changed_q;
    init_d    = init_q;
    status_d  = status_q;
    case (state_q)
      S_INIT1: begin
        work_d[~idx_q] = tile;
        idx_d          = lfsr_q[3:0];
        state_d        = S_INIT2;
      end
      S_INIT2, S_SPAWN: begin
        if (work_q[~idx_q] == 4'd0) begin
          work_d[~idx_q] = tile;
          state_d        = S_COMMIT;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      S_IDLE: begin
        if (press_ok) begin
          dir_d   = direction;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        work_d    = oldvalues;
        changed_d = 1'b0;
        state_d   = S_LINE0;
      end
      S_LINE0, S_LINE1, S_LINE2, S_LINE3: begin
        for (int unsigned p = 0; p < 4; p++) begin
          work_d[~line_idx[2'(p)]] = line_out[2'(p)];
        end
        changed_d = changed_q | (line_out != line_in);
        if (state_q == S_LINE3) begin
          if (changed_d) begin
            idx_d   = lfsr_q[3:0];
            state_d = S_SPAWN;
          end else begin
            state_d = S_WAIT;
          end
        end else begin
          state_d = state_q + 4'd1;
        end
      end
      S_COMMIT: begin
        // Status is latched on the edge ending COMMIT, so it is already valid during CHECK.
        if (init_q) begin
          init_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          if (status_q == 2'b00) status_d = board_status(work_q);
          state_d = S_CHECK;
        end
      end
      S_CHECK: state_d = S_WAIT;
      S_WAIT: begin
        if (direction == 4'd0) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_INIT1;
      work_q    <= '0;
      lfsr_q    <= SEED;
      dir_q     <= '0;
      idx_q     <= SEED[3:0];
      changed_q <= 1'b0;
      init_q    <= 1'b1;
      status_q  <= 2'b00;
    end else begin
      state_q   <= state_d;
      work_q    <= work_d;
      lfsr_q    <= lfsr_d;
      dir_q     <= dir_d;
      idx_q     <= idx_d;
      changed_q <= changed_d;
      init_q    <= init_d;
      status_q  <= status_d;
    end
  end

  assign newvalues = work_q;
  assign enable    = (state_q == S_COMMIT);
  assign busy      = (state_q != S_IDLE);
  assign endstatus = status_q;

endmodule

// File: tb/tb_move_sequencer.sv
// Self-checking bench for move_sequencer: the bench plays the box array and predicts every move from the game rules.
module tb_move_sequencer;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic [3:0]  direction = 4'd0;
  logic [63:0] board = 64'd0;
  logic [63:0] oldvalues;
  logic [63:0] newvalues;
  logic        enable;
  logic        busy;
  logic [1:0]  endstatus;

  int errors = 0;
  int checks = 0;
  logic [15:0] m_lfsr;
  logic [1:0]  m_status = 2'b00;

  assign oldvalues = board;

  always #5 clock = ~clock;

  move_sequencer #(.SEED(16'hACE1), .WIN_EXP(11)) dut (
    .clock(clock), .resetn(resetn), .direction(direction), .oldvalues(oldvalues),
    .newvalues(newvalues), .enable(enable), .busy(busy), .endstatus(endstatus)
  );

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    int x, fb;
    x  = int'(v);
    fb = (x ^ (x >> 2) ^ (x >> 3) ^ (x >> 5)) & 1;
    return 16'((x >> 1) | (fb << 15));
  endfunction

  always @(posedge clock or negedge resetn)
    if (!resetn) m_lfsr <= 16'hACE1;
    else         m_lfsr <= lfsr_next(m_lfsr);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic int getc(input logic [63:0] b, input int i);
    return int'(b[63-4*i -: 4]);
  endfunction

  function automatic logic [63:0] setc(input logic [63:0] b, input int i, input int v);
    logic [63:0] r;
    r = b;
    r[63-4*i -: 4] = 4'(v);
    return r;
  endfunction

  // Slide every line toward the head, merging equal neighbours once each.
  task automatic ref_move(input logic [63:0] b, input logic [3:0] dir,
                          output logic [63:0] nb, output bit changed);
    int idx[4];
    int q[$];
    int o[$];
    int j;
    nb = b;
    changed = 0;
    for (int k = 0; k < 4; k++) begin
      for (int p = 0; p < 4; p++) begin
        case (dir)
          4'b1000: idx[p] = p * 4 + k;
          4'b0100: idx[p] = (3 - p) * 4 + k;
          4'b0010: idx[p] = k * 4 + p;
          default: idx[p] = k * 4 + (3 - p);
        endcase
      end
      q.delete();
      o.delete();
      for (int p = 0; p < 4; p++) if (getc(b, idx[p]) != 0) q.push_back(getc(b, idx[p]));
      j = 0;
      while (j < q.size()) begin
        if (j + 1 < q.size() && q[j] == q[j+1] && q[j] != 15) begin
          o.push_back(q[j] + 1);
          j += 2;
        end else begin
          o.push_back(q[j]);
          j += 1;
        end
      end
      while (o.size() < 4) o.push_back(0);
      for (int p = 0; p < 4; p++) begin
        if (o[p] != getc(b, idx[p])) changed = 1;
        nb = setc(nb, idx[p], o[p]);
      end
    end
  endtask

  function automatic logic [1:0] ref_status(input logic [63:0] b);
    bit won, empty, pair;
    won = 0; empty = 0; pair = 0;
    for (int i = 0; i < 16; i++) begin
      if (getc(b, i) >= 11) won = 1;
      if (getc(b, i) == 0) empty = 1;
    end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++) begin
        if (getc(b, r*4 + c) == getc(b, r*4 + c + 1)) pair = 1;
        if (getc(b, c*4 + r) == getc(b, (c+1)*4 + r)) pair = 1;
      end
    if (won) return 2'b01;
    if (!empty && !pair) return 2'b10;
    return 2'b00;
  endfunction

  task automatic init_seq();
    int cnt, ecyc, nz;
    bit cells_ok;
    logic [63:0] nv;
    cnt = 0; ecyc = 0; nv = 64'd0;
    resetn = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clock);
      if (enable === 1'b1) begin
        cnt++;
        ecyc = n;
        nv = newvalues;
      end
    end
    chk("init_enable_count", 64'(cnt), 64'd1);
    chk("init_enable_in_window", 64'(ecyc >= 3 && ecyc <= 33), 64'd1);
    chk("init_enable_cycle", 64'(ecyc), 64'd3);
    nz = 0;
    cells_ok = 1;
    for (int i = 0; i < 16; i++) begin
      if (getc(nv, i) != 0) begin
        nz++;
`ifdef FOUR_TILE_EN
        if (getc(nv, i) != 1 && getc(nv, i) != 2) cells_ok = 0;
`else
        if (getc(nv, i) != 1) cells_ok = 0;
`endif
      end
    end
    chk("init_tile_count", 64'(nz), 64'd2);
    chk("init_tile_values", 64'(cells_ok), 64'd1);
`ifndef FOUR_TILE_EN
    chk("init_board", nv, 64'h0110_0000_0000_0000);
`endif
    chk("init_busy_done", 64'(busy), 64'd0);
    chk("init_endstatus", 64'(endstatus), 64'd0);
    board = nv;
  endtask

  task automatic assert_reset();
    @(negedge clock);
    resetn = 1'b0;
    direction = 4'd0;
    board = 64'd0;
    m_status = 2'b00;
    #1;
    chk("reset_newvalues", newvalues, 64'd0);
    chk("reset_enable", 64'(enable), 64'd0);
    chk("reset_busy", 64'(busy), 64'd1);
    chk("reset_endstatus", 64'(endstatus), 64'd0);
    @(negedge clock);
  endtask

  // Drive one press held for h cycles and check every output on every cycle.
  task automatic do_move(input logic [3:0] dir, input int h);
    logic [63:0] mb, nv_a, nv_b, committed;
    bit ch, acc, ok;
    int s, idx, L, nfall, ecyc, start;
    acc = ($countones(dir) == 1) && (m_status == 2'b00);
    ref_move(board, dir, mb, ch);
    s = 0; idx = 0; ecyc = 1000; nfall = acc ? 1000 : 0;
    L = ((h > 25) ? h : 25) + 3;
    direction = dir;
    for (int n = 1; n <= L; n++) begin
      @(negedge clock);
      if (acc && n == 5) begin
        start = int'(m_lfsr[3:0]);
        idx = start;
        if (ch) begin
          for (int c = 0; c < 16; c++) begin
            idx = (start + c) % 16;
            s = c;
            if (getc(mb, idx) == 0) break;
          end
          ecyc = 7 + s;
        end
        nfall = (((ch ? 9 + s : 6) > h) ? (ch ? 9 + s : 6) : h) + 1;
      end
      chk("busy", 64'(busy), 64'(acc && n < nfall));
      chk("enable", 64'(enable), 64'(acc && ch && n == ecyc));
      chk("endstatus", 64'(endstatus), 64'(m_status));
      if (enable === 1'b1) board = newvalues;
      if (acc && ch && n == ecyc) begin
        nv_a = setc(mb, idx, 1);
        nv_b = setc(mb, idx, 2);
        ok = (newvalues === nv_a);
`ifdef FOUR_TILE_EN
        ok = ok || (newvalues === nv_b);
`endif
        checks++;
        if (!ok) begin
          errors++;
          $display("FAIL spawn_board: got %h, expected %h", newvalues, nv_a);
        end
        committed = (ok && newvalues === nv_b) ? nv_b : nv_a;
        if (m_status == 2'b00) m_status = ref_status(committed);
      end
      if (n == h) direction = 4'd0;
    end
  endtask

  initial begin
    logic [63:0] mb;
    bit ch;
    logic [3:0] dir;
    int v;

    resetn = 1'b0;
    repeat (3) @(negedge clock);
    chk("por_newvalues", newvalues, 64'd0);
    chk("por_enable", 64'(enable), 64'd0);
    chk("por_busy", 64'(busy), 64'd1);
    chk("por_endstatus", 64'(endstatus), 64'd0);
    init_seq();

    // Row 0 = {1,1,2,0}: one merge only, no chaining into the 2.
    board = 64'h1120_0000_0000_0000;
    ref_move(board, 4'b0010, mb, ch);
    chk("model_left", mb, 64'h2200_0000_0000_0000);
    do_move(4'b0010, 3);

    board = 64'h1000_1000_1000_1000;
    ref_move(board, 4'b1000, mb, ch);
    chk("model_up", mb, 64'h2000_2000_0000_0000);
    ref_move(board, 4'b0100, mb, ch);
    chk("model_down", mb, 64'h0000_0000_2000_2000);
    do_move(4'b1000, 4);
    board = 64'h1000_1000_1000_1000;
    do_move(4'b0100, 2);

    board = 64'h1200_3000_1000_0000;
    ref_move(board, 4'b0010, mb, ch);
    chk("model_nochange", 64'(ch), 64'd0);
    do_move(4'b0010, 15);

    do_move(4'b0101, 20);
    do_move(4'b0000, 20);
    board = 64'h0100_0000_0000_0000;
    do_move(4'b0010, 100);

    board = 64'h0232_3232_2323_3232;
    do_move(4'b0010, 5);
`ifndef FOUR_TILE_EN
    chk("lost_status", 64'(endstatus), 64'd2);
`endif
    do_move(4'b0001, 5);
    assert_reset();
    init_seq();

    board = 64'hAA00_0000_0000_0000;
    ref_move(board, 4'b0010, mb, ch);
    chk("model_win", mb, 64'hB000_0000_0000_0000);
    do_move(4'b0010, 5);
    chk("won_status", 64'(endstatus), 64'd1);
    board = 64'h1100_0000_0000_0000;
    do_move(4'b0010, 8);

    // Abort in LINE2 after a fresh init.
    assert_reset();
    init_seq();
    board = 64'h1100_2200_0000_0000;
    direction = 4'b0010;
    repeat (4) @(negedge clock);
    chk("midmove_busy", 64'(busy), 64'd1);
    resetn = 1'b0;
    #1;
    chk("abort_newvalues", newvalues, 64'd0);
    chk("abort_enable", 64'(enable), 64'd0);
    chk("abort_busy", 64'(busy), 64'd1);
    chk("abort_endstatus", 64'(endstatus), 64'd0);
    direction = 4'd0;
    board = 64'd0;
    m_status = 2'b00;
    @(negedge clock);
    init_seq();

    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        for (int i = 0; i < 16; i++) begin
          v = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 5));
          board = setc(board, i, v);
        end
      end
      dir = 4'(1 << $urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) dir = 4'($urandom_range(0, 15));
      do_move(dir, int'($urandom_range(1, 30)));
      if (m_status != 2'b00) begin
        assert_reset();
        init_seq();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/move_sequencer.md
# move_sequencer

Sequences one complete 2048 move across the 16 `box` registers. It latches a direction press and processes the four rows or columns one per cycle through a single shared line-merge unit. It then spawns a new tile in an empty cell, issues one write strobe to all boxes and updates the win/lose status. It sits between the direction input and the box array, alongside `draw_grid`, and spawns the two opening tiles after reset.

## Interface
Parameters:
- `SEED`, 16'hACE1: LFSR reset value; must be non-zero.
- `WIN_EXP`, 11: tile exponent that wins the game (2^11 = 2048).

Ports:
- `clock`  in  1  system clock; all state is on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `direction`  in  4  one-hot press: [3] up, [2] down, [1] left, [0] right.
- `oldvalues`  in  64  current board; cell i (i = row*4+col, row 0 = top) is at [63-4i -: 4].
- `newvalues`  out  64  next board, same packing; driven from the work register.
- `enable`  out  1  one-cycle write strobe to all boxes.
- `busy`  out  1  high in every state except IDLE.
- `endstatus`  out  2  00 = playing, 01 = won, 10 = lost; sticky until reset.

## Operation
- Tile encoding: 4-bit exponent; 0 = empty; n = 2^n.
- Press qualification:
  - A press is accepted only in IDLE, only with exactly one `direction` bit set, and only while `endstatus` == 00.
  - Zero or multiple bits are ignored.
  - After each move, `direction` must return to 4'b0000 (WAIT_RELEASE) before the next press is accepted.
- States:
  - INIT1, INIT2: spawn one tile each into the work register (reset to all-zero), then go to COMMIT.
  - IDLE: on an accepted press, latch the direction and go to LOAD.
  - LOAD: work register <= `oldvalues`; changed flag <= 0.
  - LINE0..LINE3: one line per state, through the shared merge unit, written back in place.
  - SPAWN: scan for an empty cell.
  - COMMIT: drive `enable` = 1.
  - CHECK: update `endstatus`.
  - WAIT_RELEASE: hold until `direction` == 0, then IDLE. After INIT, COMMIT goes straight to IDLE.
- Line extraction, head first:
  - left: row k, columns 0..3.
  - right: row k, columns 3..0.
  - up: column k, rows 0..3.
  - down: column k, rows 3..0.
- Merge unit (combinational):
  - Compacts non-zero cells toward the head.
  - Merges each adjacent equal pair once, scanning from the head; a merged tile is not merged again in the same move.
  - A merged pair becomes exponent+1. Pairs at exponent 15 are not merged (saturation).
  - The changed flag is set if any output line differs from its input.
- After LINE3, if changed == 0, skip SPAWN and COMMIT, go to WAIT_RELEASE, and leave `enable` low.
- SPAWN scan:
  - Index starts at `lfsr[3:0]` and advances by 1 each cycle, wrapping 15->0.
  - The first empty cell found receives the new tile; then COMMIT.
- LFSR: free-running 16-bit Fibonacci LFSR, taps 16,14,13,11; reset to `SEED`.
- CHECK, using the committed board:
  - won if any cell >= `WIN_EXP`.
  - else lost if no cell is empty and no horizontally or vertically adjacent pair is equal.
  - else playing.

## Timing
- Reset values:
  - `enable` = 0, `busy` = 1 (state INIT1), `endstatus` = 00.
  - `newvalues` = 0, `lfsr` = `SEED`.
- An asserted `resetn` mid-move aborts the move immediately; the boxes share the reset and clear as well.
- A press sampled in IDLE at edge t gives:
  - LOAD at t+1, LINE0..3 at t+2..t+5, SPAWN from t+6.
  - `enable` high for exactly one cycle, at t+7 at the earliest. The latest is t+22 with a 16-cycle scan.
- `newvalues` is stable during the whole `enable` cycle; the boxes capture on the edge that ends it.
- `endstatus` is valid from the cycle after COMMIT.
- An unchanged move asserts `enable` zero times.
- A changed move always leaves at least one empty cell, so the spawn always terminates within 16 cycles.
- INIT: the two spawns always land in distinct cells, because the second scan skips the first tile. The first `enable` is asserted 3–33 cycles after reset release.

## Configuration
- `FOUR_TILE_EN` defined: a spawned tile is exponent 2 (value 4) when `lfsr[7:4]` == 0, otherwise exponent 1.
- Undefined: every spawned tile is exponent 1 (value 2).

## Test plan
- Reset release with `SEED` = 16'hACE1:
  - exactly one `enable` pulse.
  - exactly two non-zero cells, each exponent 1 (or 2 under `FOUR_TILE_EN`).
  - `endstatus` = 00.
- Row 0 = {1,1,2,0}, rest empty, press left:
  - row 0 becomes {2,2,0,0}; no chained merge.
  - one spawned tile in a previously empty cell.
  - `enable` asserted 7 cycles after the sampling edge when the spawn start cell is empty.
- Column 0 = {1,1,1,1}, press up:
  - column 0 becomes {2,2,0,0}.
  - press down on the original board instead gives column 0 = {0,0,2,2}.
- Board with every tile already at the left edge and no pairs, press left:
  - no `enable`; `busy` falls after WAIT_RELEASE once `direction` = 0.
- Direction values 4'b0101 and 4'b0000:
  - ignored; holding 4'b0010 for 100 cycles produces exactly one move.
- Two 10-tiles merge into exponent 11: `endstatus` = 01, and later presses are ignored. A full board with no adjacent equal pair after commit: `endstatus` = 10. `resetn` low mid-LINE2: all outputs return to their reset values at once.
